// File: rtl/wheel_pwm_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wheel_pwm_driver_pkg
// Description : Shared definitions for the wheel PWM driver. Holds the FSM
//               state encoding, the H-bridge direction pin encoding and the
//               setpoint word format defaults shared with the movement
//               controller that produces the wheel-speed setpoints.
// Revision    : 1.0 - initial release
// ============================================================================
package wheel_pwm_driver_pkg;

  // Setpoint word format shared with the movement controller (W1..W4 words).
  localparam int unsigned C_SETPOINT_N_WIDTH = 32;
  localparam int unsigned C_SETPOINT_Q_WIDTH = 15;

  // Drive state machine.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } state_e;

  // H-bridge direction pins {IN1, IN2}.
  typedef enum logic [1:0] {
    DIR_OFF = 2'b00,
    DIR_REV = 2'b01,
    DIR_FWD = 2'b10,
    DIR_BRK = 2'b11
  } dir_e;

endpackage : wheel_pwm_driver_pkg
`default_nettype wire

// File: rtl/wheel_pwm_driver_pwm_core.sv
`default_nettype none
// ============================================================================
// Module      : wheel_pwm_driver_pwm_core
// Description : Free-running PWM period counter with a boundary pulse and a
//               registered duty comparator.
//   clk_i      - system clock
//   rst_i      - synchronous active-high reset
//   duty_i     - duty in counts, 0 .. 2^PWM_BITS-1
//   pwm_o      - registered (counter < duty)
//   boundary_o - high for the one clock where the counter sits at its maximum
// Revision    : 1.0 - initial release
// ============================================================================
module wheel_pwm_driver_pwm_core
  import wheel_pwm_driver_pkg::*;
#(
  parameter int unsigned PWM_BITS = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o,
  output logic                boundary_o
);

  logic [PWM_BITS-1:0] cnt_q;
  logic                pwm_q;

  // The counter never stops: the enable cut-off and every drive state rely
  // on the period grid staying intact so re-entry is boundary-aligned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
      pwm_q <= (cnt_q < duty_i);
    end
  end

  assign boundary_o = (cnt_q == {PWM_BITS{1'b1}});
  assign pwm_o      = pwm_q;

endmodule : wheel_pwm_driver_pwm_core
`default_nettype wire

// File: rtl/wheel_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : wheel_pwm_driver
// Description : Converts one signed fixed-point wheel-speed setpoint into an
//               H-bridge drive (PWM + two direction pins). Scales and clips
//               the setpoint to a duty, slew-limits the duty once per PWM
//               period, sequences direction reversals through a dead phase
//               and cuts the drive immediately when ENABLE drops.
//   WHEEL_PWM_DRIVER_CLOCK_50     - system clock
//   WHEEL_PWM_DRIVER_RESET_InHigh - synchronous active-high reset
//   WHEEL_PWM_DRIVER_SPEED_InBus  - signed Q(N-Q).Q setpoint, rad/s
//   WHEEL_PWM_DRIVER_ENABLE_In    - drive enable, low = emergency stop
//   WHEEL_PWM_DRIVER_PWM_Out      - PWM to bridge enable
//   WHEEL_PWM_DRIVER_DIRA_Out     - bridge IN1
//   WHEEL_PWM_DRIVER_DIRB_Out     - bridge IN2
//   WHEEL_PWM_DRIVER_DUTY_OutBus  - duty currently applied
//   WHEEL_PWM_DRIVER_SAT_Out      - last sampled setpoint was clipped
// Build option: WHEEL_PWM_BRAKE_EN - when defined, the dead phase actively
//               brakes (both direction pins and PWM high) instead of coasting.
// Revision    : 1.0 - initial release
// ============================================================================
module wheel_pwm_driver
  import wheel_pwm_driver_pkg::*;
#(
  parameter int unsigned N_WIDTH      = C_SETPOINT_N_WIDTH,
  parameter int unsigned Q_WIDTH      = C_SETPOINT_Q_WIDTH,
  parameter int unsigned PWM_BITS     = 10,
  parameter int unsigned DUTY_GAIN    = 40,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int unsigned DEAD_PERIODS = 4
) (
  input  logic                WHEEL_PWM_DRIVER_CLOCK_50,
  input  logic                WHEEL_PWM_DRIVER_RESET_InHigh,
  input  logic [N_WIDTH-1:0]  WHEEL_PWM_DRIVER_SPEED_InBus,
  input  logic                WHEEL_PWM_DRIVER_ENABLE_In,
  output logic                WHEEL_PWM_DRIVER_PWM_Out,
  output logic                WHEEL_PWM_DRIVER_DIRA_Out,
  output logic                WHEEL_PWM_DRIVER_DIRB_Out,
  output logic [PWM_BITS-1:0] WHEEL_PWM_DRIVER_DUTY_OutBus,
  output logic                WHEEL_PWM_DRIVER_SAT_Out
);

  localparam int unsigned         C_PROD_W    = N_WIDTH + 16;
  localparam logic [PWM_BITS-1:0] C_DMAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] C_STEP      = PWM_BITS'(RAMP_STEP);
  localparam int unsigned         C_DEAD_W    = (DEAD_PERIODS < 1) ? 1 : $clog2(DEAD_PERIODS + 1);
  localparam logic [C_DEAD_W-1:0] C_DEAD_LOAD = C_DEAD_W'(DEAD_PERIODS);

  // --------------------------------------------------------------------------
  // Setpoint scaling: |speed| * gain >> Q, clipped to the duty range.
  // --------------------------------------------------------------------------
  logic                speed_neg;
  logic [N_WIDTH-1:0]  mag;
  logic [C_PROD_W-1:0] prod;
  logic [C_PROD_W-1:0] scaled;
  logic                clip;
  logic [PWM_BITS-1:0] tgt;

  always_comb begin
    speed_neg = WHEEL_PWM_DRIVER_SPEED_InBus[N_WIDTH-1];
    // The most negative word has no positive counterpart; pin it to the
    // largest positive magnitude instead of letting negation wrap.
    if (WHEEL_PWM_DRIVER_SPEED_InBus == {1'b1, {(N_WIDTH-1){1'b0}}}) begin
      mag = {1'b0, {(N_WIDTH-1){1'b1}}};
    end else if (speed_neg) begin
      mag = ~WHEEL_PWM_DRIVER_SPEED_InBus + N_WIDTH'(1);
    end else begin
      mag = WHEEL_PWM_DRIVER_SPEED_InBus;
    end
    prod   = C_PROD_W'(mag) * C_PROD_W'(DUTY_GAIN);
    scaled = prod >> Q_WIDTH;
    clip   = (scaled > C_PROD_W'(C_DMAX));
    tgt    = clip ? C_DMAX : scaled[PWM_BITS-1:0];
  end

  // Move cur toward goal by at most one ramp step, landing exactly on goal.
  function automatic logic [PWM_BITS-1:0] ramp_toward(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] goal
  );
    logic [PWM_BITS-1:0] diff;
    if (cur < goal) begin
      diff = goal - cur;
      return (diff > C_STEP) ? (cur + C_STEP) : goal;
    end else begin
      diff = cur - goal;
      return (diff > C_STEP) ? (cur - C_STEP) : goal;
    end
  endfunction

  // --------------------------------------------------------------------------
  // PWM period counter and comparator.
  // --------------------------------------------------------------------------
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_cmp;
  logic                core_pwm;
  logic                boundary;

  // Zeroing the compare input while disabled makes the registered PWM drop
  // on the very next edge, not one period later.
  assign duty_cmp = WHEEL_PWM_DRIVER_ENABLE_In ? duty_q : '0;

  wheel_pwm_driver_pwm_core #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_core (
    .clk_i      (WHEEL_PWM_DRIVER_CLOCK_50),
    .rst_i      (WHEEL_PWM_DRIVER_RESET_InHigh),
    .duty_i     (duty_cmp),
    .pwm_o      (core_pwm),
    .boundary_o (boundary)
  );

  // --------------------------------------------------------------------------
  // Drive state machine.
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [C_DEAD_W-1:0] dead_q, dead_d;
  logic                sat_q, sat_d;
  logic                opposite;

  always_ff @(posedge WHEEL_PWM_DRIVER_CLOCK_50) begin
    if (WHEEL_PWM_DRIVER_RESET_InHigh) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      dead_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    dead_d   = dead_q;
    sat_d    = sat_q;
    opposite = 1'b0;

    if (!WHEEL_PWM_DRIVER_ENABLE_In) begin
      // Emergency stop acts on any clock, not just at a boundary.
      state_d = ST_IDLE;
      duty_d  = '0;
      dead_d  = '0;
    end else if (boundary) begin
      sat_d = clip;
      case (state_q)
        ST_IDLE: begin
          if (tgt != '0) begin
            state_d = speed_neg ? ST_REV : ST_FWD;
            duty_d  = ramp_toward(duty_q, tgt);
          end
        end

        ST_FWD, ST_REV: begin
          // A zero target carries no direction, so it never counts as a
          // reversal request; it simply ramps down and parks in IDLE.
          opposite = (tgt != '0) && (speed_neg != (state_q == ST_REV));
          if (opposite) begin
            if (duty_q == '0) begin
              state_d = ST_DEAD;
              dead_d  = C_DEAD_LOAD;
            end else begin
              duty_d = ramp_toward(duty_q, '0);
            end
          end else if ((tgt == '0) && (duty_q == '0)) begin
            state_d = ST_IDLE;
          end else begin
            duty_d = ramp_toward(duty_q, tgt);
          end
        end

        ST_DEAD: begin
          duty_d = '0;
          // Leaving on the boundary that would take the count to zero gives
          // exactly DEAD_PERIODS full periods in DEAD.
          if (dead_q <= C_DEAD_W'(1)) begin
            state_d = ST_IDLE;
            dead_d  = '0;
          end else begin
            dead_d = dead_q - C_DEAD_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
          dead_d  = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bridge outputs.
  // --------------------------------------------------------------------------
  dir_e dir;
  logic dead_drive;

  always_comb begin
    dir        = DIR_OFF;
    dead_drive = 1'b0;
    case (state_q)
      ST_FWD:  dir = DIR_FWD;
      ST_REV:  dir = DIR_REV;
      ST_DEAD: begin
`ifdef WHEEL_PWM_BRAKE_EN
        // Short the motor terminals through the bridge for active braking.
        dir        = DIR_BRK;
        dead_drive = 1'b1;
`else
        dir        = DIR_OFF;
        dead_drive = 1'b0;
`endif
      end
      default: dir = DIR_OFF;
    endcase
  end

  assign WHEEL_PWM_DRIVER_PWM_Out     = core_pwm | dead_drive;
  assign WHEEL_PWM_DRIVER_DIRA_Out    = dir[1];
  assign WHEEL_PWM_DRIVER_DIRB_Out    = dir[0];
  assign WHEEL_PWM_DRIVER_DUTY_OutBus = duty_q;
  assign WHEEL_PWM_DRIVER_SAT_Out     = sat_q;

endmodule : wheel_pwm_driver
`default_nettype wire
